// File: rtl/cgra_config_pkg.sv
// Shared types for the CGRA configuration path: loader FSM states and the packed PE config entry.
package cgra_config_pkg;

  localparam int PE_ROW_BIT_LENGTH       = 3;
  localparam int PE_COLUMN_BIT_LENGTH    = 3;
  localparam int INPUT_NUM_BIT_LENGTH    = 3;
  localparam int OPERATION_BIT_LENGTH    = 5;
  localparam int DATA_WIDTH              = 16;
  localparam int CONTEXT_SIZE_BIT_LENGTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    START = 2'd3
  } loader_state_t;

  // Row/column are one bit wider than the default array needs so out-of-range targets are expressible.
  typedef struct packed {
    logic [PE_ROW_BIT_LENGTH-1:0]       row;
    logic [PE_COLUMN_BIT_LENGTH-1:0]    column;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    in1;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    in2;
    logic [OPERATION_BIT_LENGTH-1:0]    op;
    logic [DATA_WIDTH-1:0]              const_data;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] ctx;
  } cfg_entry_t;

endpackage

// File: rtl/cgra_config_loader_if.sv
// Valid/ready stream carrying one PE configuration entry per beat from the host into the loader.
interface cgra_config_loader_if;
  import cgra_config_pkg::*;

  logic                               cfg_valid;
  logic                               cfg_ready;
  logic [PE_ROW_BIT_LENGTH-1:0]       cfg_row;
  logic [PE_COLUMN_BIT_LENGTH-1:0]    cfg_column;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_index_1;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_index_2;
  logic [OPERATION_BIT_LENGTH-1:0]    cfg_op;
  logic [DATA_WIDTH-1:0]              cfg_const_data;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cfg_context_index;

  modport master (
    output cfg_valid, cfg_row, cfg_column, cfg_input_index_1, cfg_input_index_2,
           cfg_op, cfg_const_data, cfg_context_index,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_row, cfg_column, cfg_input_index_1, cfg_input_index_2,
           cfg_op, cfg_const_data, cfg_context_index,
    output cfg_ready
  );

endinterface

// File: rtl/cgra_config_loader.sv
// Replays streamed PE config entries as write_config_data pulses, then fires start_exec once per session.
// CGRA_CONFIG_LOADER_CHECKSUM_EN adds a CHECK state consuming an XOR trailer beat before START.
module cgra_config_loader
  import cgra_config_pkg::*;
#(
  parameter int PE_ROW_SIZE       = 4,
  parameter int PE_COLUMN_SIZE    = 4,
  parameter int ENTRY_COUNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               load_start,
  input  logic [ENTRY_COUNT_WIDTH-1:0]       load_entry_count,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] load_context_max_id,
  input  logic                               load_abort,
  cgra_config_loader_if.slave                cfg,
  output logic [PE_ROW_BIT_LENGTH-1:0]       config_PE_row_index,
  output logic [PE_COLUMN_BIT_LENGTH-1:0]    config_PE_column_index,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
  output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
  output logic [DATA_WIDTH-1:0]              config_const_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
  output logic                               write_config_data,
  output logic                               start_exec,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
  output logic                               busy,
  output logic                               done,
  output logic                               error
);

  loader_state_t                      state_q, state_d;
  logic [ENTRY_COUNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id_q, max_id_d;
  cfg_entry_t                         entry_q, entry_d;
  logic                               err_q, err_d;
  logic                               wr_q, wr_d;
  logic                               start_q, start_d;
  logic                               done_q, done_d;
`ifdef CGRA_CONFIG_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]              csum_q, csum_d;
`endif

  cfg_entry_t in_entry;
  logic       in_range;

  always_comb begin
    in_entry.row        = cfg.cfg_row;
    in_entry.column     = cfg.cfg_column;
    in_entry.in1        = cfg.cfg_input_index_1;
    in_entry.in2        = cfg.cfg_input_index_2;
    in_entry.op         = cfg.cfg_op;
    in_entry.const_data = cfg.cfg_const_data;
    in_entry.ctx        = cfg.cfg_context_index;
    in_range = (int'(cfg.cfg_row) < PE_ROW_SIZE) && (int'(cfg.cfg_column) < PE_COLUMN_SIZE);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    max_id_d      = max_id_q;
    entry_d       = entry_q;
    err_d         = err_q;
    wr_d          = 1'b0;
    start_d       = 1'b0;
    done_d        = 1'b0;
    cfg.cfg_ready = 1'b0;
`ifdef CGRA_CONFIG_LOADER_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          cnt_d    = load_entry_count;
          max_id_d = load_context_max_id;
          err_d    = 1'b0;
`ifdef CGRA_CONFIG_LOADER_CHECKSUM_EN
          csum_d   = '0;
`endif
          state_d  = (load_entry_count == '0) ? START : LOAD;
        end
      end
      LOAD: begin
        // Abort withholds ready so a coincident beat is never taken.
        cfg.cfg_ready = !load_abort;
        if (load_abort) begin
          state_d = IDLE;
        end else if (cfg.cfg_valid) begin
          entry_d = in_entry;
          wr_d    = in_range;
          if (!in_range) err_d = 1'b1;
          cnt_d   = cnt_q - ENTRY_COUNT_WIDTH'(1);
`ifdef CGRA_CONFIG_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ cfg.cfg_const_data;
          if (cnt_q == ENTRY_COUNT_WIDTH'(1)) state_d = CHECK;
`else
          if (cnt_q == ENTRY_COUNT_WIDTH'(1)) state_d = START;
`endif
        end
      end
`ifdef CGRA_CONFIG_LOADER_CHECKSUM_EN
      CHECK: begin
        cfg.cfg_ready = !load_abort;
        if (load_abort) begin
          state_d = IDLE;
        end else if (cfg.cfg_valid) begin
          if (csum_q != cfg.cfg_const_data) err_d = 1'b1;
          state_d = START;
        end
      end
`endif
      START: begin
        if (load_abort) begin
          state_d = IDLE;
        end else begin
          start_d = !err_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      max_id_q <= '0;
      entry_q  <= '0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef CGRA_CONFIG_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      max_id_q <= max_id_d;
      entry_q  <= entry_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      start_q  <= start_d;
      done_q   <= done_d;
`ifdef CGRA_CONFIG_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign config_PE_row_index     = entry_q.row;
  assign config_PE_column_index  = entry_q.column;
  assign config_input_PE_index_1 = entry_q.in1;
  assign config_input_PE_index_2 = entry_q.in2;
  assign config_op               = entry_q.op;
  assign config_const_data       = entry_q.const_data;
  assign config_index            = entry_q.ctx;
  assign write_config_data       = wr_q;
  assign start_exec              = start_q;
  assign done                    = done_q;
  assign error                   = err_q;
  assign mapping_context_max_id  = max_id_q;
  assign busy                    = (state_q != IDLE);

endmodule

// File: tb/tb_cgra_config_loader.sv
// Directed + randomized sessions scored against a transaction-level model of expected pulses.
module tb_cgra_config_loader;
  import cgra_config_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef struct {
    int         cyc;
    cfg_entry_t e;
  } pulse_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_start = 1'b0;
  logic [15:0] load_entry_count = '0;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] load_context_max_id = '0;
  logic        load_abort = 1'b0;

  logic [PE_ROW_BIT_LENGTH-1:0]       config_PE_row_index;
  logic [PE_COLUMN_BIT_LENGTH-1:0]    config_PE_column_index;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2;
  logic [OPERATION_BIT_LENGTH-1:0]    config_op;
  logic [DATA_WIDTH-1:0]              config_const_data;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index;
  logic write_config_data, start_exec, busy, done, error;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id;

  cgra_config_loader_if cfg();

  cgra_config_loader #(.PE_ROW_SIZE(ROWS), .PE_COLUMN_SIZE(COLS), .ENTRY_COUNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .load_start(load_start), .load_entry_count(load_entry_count),
    .load_context_max_id(load_context_max_id), .load_abort(load_abort),
    .cfg(cfg),
    .config_PE_row_index(config_PE_row_index), .config_PE_column_index(config_PE_column_index),
    .config_input_PE_index_1(config_input_PE_index_1), .config_input_PE_index_2(config_input_PE_index_2),
    .config_op(config_op), .config_const_data(config_const_data), .config_index(config_index),
    .write_config_data(write_config_data), .start_exec(start_exec),
    .mapping_context_max_id(mapping_context_max_id),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  pulse_t     obs_wr[$];
  pulse_t     exp_wr[$];
  int         obs_start[$];
  int         obs_done[$];
  cfg_entry_t stim[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset_n) begin
      if (write_config_data) begin
        pulse_t p;
        p.cyc          = cyc;
        p.e.row        = config_PE_row_index;
        p.e.column     = config_PE_column_index;
        p.e.in1        = config_input_PE_index_1;
        p.e.in2        = config_input_PE_index_2;
        p.e.op         = config_op;
        p.e.const_data = config_const_data;
        p.e.ctx        = config_index;
        obs_wr.push_back(p);
      end
      if (start_exec) obs_start.push_back(cyc);
      if (done)       obs_done.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input cfg_entry_t e, input logic v);
    cfg.cfg_valid         = v;
    cfg.cfg_row           = e.row;
    cfg.cfg_column        = e.column;
    cfg.cfg_input_index_1 = e.in1;
    cfg.cfg_input_index_2 = e.in2;
    cfg.cfg_op            = e.op;
    cfg.cfg_const_data    = e.const_data;
    cfg.cfg_context_index = e.ctx;
  endtask

  function automatic cfg_entry_t rand_entry(input int rc_max);
    cfg_entry_t e;
    e.row        = PE_ROW_BIT_LENGTH'($urandom_range(0, rc_max));
    e.column     = PE_COLUMN_BIT_LENGTH'($urandom_range(0, rc_max));
    e.in1        = INPUT_NUM_BIT_LENGTH'($urandom);
    e.in2        = INPUT_NUM_BIT_LENGTH'($urandom);
    e.op         = OPERATION_BIT_LENGTH'($urandom);
    e.const_data = DATA_WIDTH'($urandom);
    e.ctx        = CONTEXT_SIZE_BIT_LENGTH'($urandom);
    return e;
  endfunction

  // Runs one session from stim[]; expected pulses land on the acceptance edge, start/done one cycle after the final beat.
  task automatic session(input string name, input int count, input logic [CONTEXT_SIZE_BIT_LENGTH-1:0] maxid,
                         input bit gaps, input int abort_at, input bit trailer_good);
    bit                    exp_err = 1'b0;
    bit                    aborted = 1'b0;
    logic [DATA_WIDTH-1:0] x = '0;
    int                    last_edge;
    cfg_entry_t            idle_e = '0;
    obs_wr.delete(); obs_start.delete(); obs_done.delete(); exp_wr.delete();
    load_start = 1'b1; load_entry_count = 16'(count); load_context_max_id = maxid;
    step();
    load_start = 1'b0;
    last_edge = cyc;
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          drive(idle_e, 1'b0);
          if ($urandom_range(0, 2) == 0) begin
            load_start = 1'b1; load_entry_count = '0; load_context_max_id = ~maxid;
          end
          step();
          load_start = 1'b0;
        end
      end
      if (i == abort_at) begin
        load_abort = 1'b1;
        drive(stim[i], 1'b1);
        step();
        load_abort = 1'b0;
        aborted = 1'b1;
        break;
      end
      drive(stim[i], 1'b1);
      @(negedge clk);
      chk({name, "_ready"}, 64'(cfg.cfg_ready), 64'(1));
      chk({name, "_busy"}, 64'(busy), 64'(1));
      step();
      if (int'(stim[i].row) < ROWS && int'(stim[i].column) < COLS) begin
        pulse_t p;
        p.cyc = cyc;
        p.e   = stim[i];
        exp_wr.push_back(p);
      end else begin
        exp_err = 1'b1;
      end
      x ^= stim[i].const_data;
      last_edge = cyc;
    end
    drive(idle_e, 1'b0);
`ifdef CGRA_CONFIG_LOADER_CHECKSUM_EN
    if (!aborted && count > 0) begin
      cfg_entry_t t = '0;
      t.const_data = trailer_good ? x : (x ^ DATA_WIDTH'(1));
      drive(t, 1'b1);
      step();
      if (!trailer_good) exp_err = 1'b1;
      last_edge = cyc;
      drive(idle_e, 1'b0);
    end
`endif
    repeat (5) step();
    chk({name, "_npulse"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      chk({name, "_pcyc"}, 64'(obs_wr[i].cyc), 64'(exp_wr[i].cyc));
      chk({name, "_pdat"}, 64'(obs_wr[i].e), 64'(exp_wr[i].e));
    end
    chk({name, "_nstart"}, 64'(obs_start.size()), 64'((aborted || exp_err) ? 0 : 1));
    if (obs_start.size() == 1 && !aborted && !exp_err)
      chk({name, "_start_cyc"}, 64'(obs_start[0]), 64'(last_edge + 1));
    chk({name, "_ndone"}, 64'(obs_done.size()), 64'(aborted ? 0 : 1));
    if (obs_done.size() == 1 && !aborted)
      chk({name, "_done_cyc"}, 64'(obs_done[0]), 64'(last_edge + 1));
    chk({name, "_error"}, 64'(error), 64'(exp_err));
    chk({name, "_maxid"}, 64'(mapping_context_max_id), 64'(maxid));
    chk({name, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    cfg_entry_t e;
    drive('0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_wr", 64'(write_config_data), 64'(0));
    chk("rst_start", 64'(start_exec), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_maxid", 64'(mapping_context_max_id), 64'(0));
    chk("rst_ready", 64'(cfg.cfg_ready), 64'(0));
    chk("rst_row", 64'(config_PE_row_index), 64'(0));
    reset_n = 1'b1;
    step();

    stim.delete();
    for (int i = 0; i < 3; i++) begin e = rand_entry(3); e.row = PE_ROW_BIT_LENGTH'(i); stim.push_back(e); end
    session("t1", 3, 4'hA, 1'b0, -1, 1'b1);

    stim.delete();
    session("t2", 0, 4'h5, 1'b0, -1, 1'b1);

    stim.delete();
    e = rand_entry(3); e.row = 3'd0; stim.push_back(e);
    e = rand_entry(3); e.row = PE_ROW_BIT_LENGTH'(ROWS); stim.push_back(e);
    session("t3", 2, 4'h3, 1'b0, -1, 1'b1);

    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(rand_entry(3));
    session("t4", 4, 4'h7, 1'b0, 2, 1'b1);

    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(rand_entry(3));
    session("t5", 8, 4'hC, 1'b1, -1, 1'b1);

    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(rand_entry(5));
    session("rnd", 10, 4'h9, 1'b1, -1, 1'b1);

    // Reset in the middle of a session.
    load_start = 1'b1; load_entry_count = 16'd3; load_context_max_id = 4'hE;
    step();
    load_start = 1'b0;
    drive(rand_entry(3), 1'b1);
    step();
    drive('0, 1'b0);
    chk("mid_wr_live", 64'(write_config_data), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("mid_busy", 64'(busy), 64'(0));
    chk("mid_wr", 64'(write_config_data), 64'(0));
    chk("mid_maxid", 64'(mapping_context_max_id), 64'(0));
    chk("mid_ready", 64'(cfg.cfg_ready), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    step();

    stim.delete();
    for (int i = 0; i < 2; i++) stim.push_back(rand_entry(3));
    session("post_rst", 2, 4'h2, 1'b0, -1, 1'b1);

`ifdef CGRA_CONFIG_LOADER_CHECKSUM_EN
    stim.delete();
    e = rand_entry(3); e.const_data = 16'h0003; stim.push_back(e);
    e = rand_entry(3); e.const_data = 16'h0005; stim.push_back(e);
    session("cs_good", 2, 4'h6, 1'b0, -1, 1'b1);
    session("cs_bad", 2, 4'h6, 1'b0, -1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
